alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the integer pipeline (port 0) and the address/branch helper (port 1).
- Each port has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, latches the operands, drives the ALU for one cycle, registers the result and holds it until the owning port accepts it.
- One operation is in flight at a time.

Parameters:
- DATA_W, 32, operand/result width; must match ALU width.
- OP_W, 4, width of the ALU control code; passed through unmodified.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid0 / req_valid1  in  1  request present on port 0 / port 1.
- req_ready0 / req_ready1  out  1  request accepted this cycle.
- req_op0 / req_op1  in  OP_W  ALU control code.
- req_a0 / req_a1  in  DATA_W  operand A.
- req_b0 / req_b1  in  DATA_W  operand B.
- resp_valid0 / resp_valid1  out  1  result available for the port.
- resp_ready0 / resp_ready1  in  1  port consumes result.
- resp_result  out  DATA_W  shared result bus, meaningful only with a resp_valid.
- alu_control  out  OP_W  to ALU aluControl.
- alu_src_a  out  DATA_W  to ALU srcA.
- alu_src_b  out  DATA_W  to ALU srcB.
- alu_result  in  DATA_W  from ALU aluResult (combinational).

Behaviour:
- Reset state:
  - State IDLE.
  - op/operand/result registers all 0.
  - owner = 0.
  - last_grant = 1, so port 0 wins the first tie.
  - All ready/valid outputs 0.
  - alu_control/alu_src_a/alu_src_b = 0.
- The ALU outputs are always driven from the op_reg/a_reg/b_reg registers, never directly from the request ports.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - req_readyN is asserted combinationally for the granted port only, and only in IDLE.
  - On the accept edge: latch op, a and b into the registers, set owner = N and last_grant = N, then go to EXEC.
  - Neither valid: stay in IDLE.
- EXEC:
  - Lasts exactly 1 cycle; the ALU sees the latched values.
  - At the clock edge, result_reg <= alu_result, then go to RESP.
- RESP:
  - resp_valid[owner] = 1; the other resp_valid = 0.
  - resp_result = result_reg.
  - When resp_ready[owner] = 1, the handshake completes at that edge and the state returns to IDLE.
  - No new request is accepted in the same cycle.
  - resp_ready of the non-owner port is ignored.
- Latency: accept at edge N, EXEC during cycle N+1, resp_valid high from cycle N+2. Minimum issue interval is 3 cycles.
- Backpressure: while the owner holds resp_ready low, the block stays in RESP indefinitely. result_reg stays stable and both req_ready outputs stay 0.
- Requester obligations: hold req_valid, op and operands stable until ready; dropping valid before ready is legal and withdraws the request.
- Operation codes: not decoded. Invalid codes return whatever the ALU produces (0 for undefined codes).
- Reset asserted mid-operation: the in-flight op is discarded and no response is issued. Registers return to reset values immediately (asynchronously).
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_SHARE_ARBITER_STATS_EN.
- When defined, adds two outputs, stat_done0 and stat_done1 (out, 16 bits each).
  - Each counts completed response handshakes for its port.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and their counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Single op: port 0, op=4'b0000, a=5, b=7, resp_ready0=1 → req_ready0 at cycle 0; resp_valid0 at cycle 2 with resp_result=12; resp_valid1 stays 0.
- Tie and fairness: both ports continuously valid, port 0 op=ADD 1+1, port 1 op=SUB 10-3, resp_ready=1 → order of service is port0 (2), port1 (7), port0 (2), port1 (7).
- Backpressure: port 1 op=AND a=32'hF0F0 b=32'hFF00, resp_ready1 low for 5 cycles → resp_result=32'hF000 held for 5 cycles; port 0 request stays un-readied until the handshake, then is accepted in the next IDLE cycle.
- Operand isolation: after accept, change req_a0/req_b0 during EXEC → result reflects the latched values only.
- Reset in EXEC: assert reset for 1 cycle during EXEC → no resp_valid ever for that op; next request behaves as from power-up, with port 0 winning a tie.
- Stats (macro defined): 3 ops on port 0 and 2 on port 1 → stat_done0=3, stat_done1=2; after reset both read 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional per-port completion counters are enabled with `define ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid0,
  input  logic              req_valid1,
  output logic              req_ready0,
  output logic              req_ready1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic              resp_valid0,
  output logic              resp_valid1,
  input  logic              resp_ready0,
  input  logic              resp_ready1,
  output logic [DATA_W-1:0] resp_result,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_src_a,
  output logic [DATA_W-1:0] alu_src_b,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  output logic [15:0]       stat_done0,
  output logic [15:0]       stat_done1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state, stateNext;
  logic [OP_W-1:0]     opReg;
  logic [DATA_W-1:0]   aReg, bReg, resultReg;
  logic                owner, lastGrant;
  logic                anyValid, grantPort, respFire;

  assign anyValid = req_valid0 || req_valid1;
  // On a tie the port that did not win last time goes first.
  assign grantPort = (req_valid0 && req_valid1) ? ~lastGrant : req_valid1;

  // The ALU only ever sees latched operands, so requesters may change theirs after accept.
  assign alu_control = opReg;
  assign alu_src_a   = aReg;
  assign alu_src_b   = bReg;
  assign resp_result = resultReg;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    stateNext   = state;
    req_ready0  = 1'b0;
    req_ready1  = 1'b0;
    resp_valid0 = 1'b0;
    resp_valid1 = 1'b0;
    respFire    = 1'b0;
    case (state)
      IDLE: begin
        if (anyValid) begin
          req_ready0 = ~grantPort;
          req_ready1 = grantPort;
          stateNext  = EXEC;
        end
      end
      EXEC: stateNext = RESP;
      RESP: begin
        resp_valid0 = ~owner;
        resp_valid1 = owner;
        respFire    = owner ? resp_ready1 : resp_ready0;
        if (respFire) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opReg     <= '0;
      aReg      <= '0;
      bReg      <= '0;
      resultReg <= '0;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
    end else begin
      state <= stateNext;
      if (state == IDLE && anyValid) begin
        opReg     <= grantPort ? req_op1 : req_op0;
        aReg      <= grantPort ? req_a1  : req_a0;
        bReg      <= grantPort ? req_b1  : req_b0;
        owner     <= grantPort;
        lastGrant <= grantPort;
      end
      if (state == EXEC) resultReg <= alu_result;
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done0 <= '0;
      stat_done1 <= '0;
    end else if (respFire) begin
      if (!owner && stat_done0 != 16'hFFFF) stat_done0 <= stat_done0 + 16'd1;
      if (owner && stat_done1 != 16'hFFFF)  stat_done1 <= stat_done1 + 16'd1;
    end
  end
`endif

endmodule
